head_merge_buffer: RTL and testbench

//  Collects BEATS = HEAD_NUM/HEADS_PER_BEAT attention-head tiles and writes them into one merged
//  [SEQ_LEN][HEAD_NUM*HEAD_DIM] matrix, reordering head-major input into row-major output.

---
 rtl/head_merge_buffer.sv | 80 ++++++++
 tb/tb_head_merge_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/head_merge_buffer.sv
// Merges head-major attention tiles into one row-major [SEQ_LEN][HEAD_NUM*HEAD_DIM] matrix.
// Valid/ready on both sides; the merged matrix is held until the consumer takes it.
module head_merge_buffer #(
   parameter int DATA_WIDTH     = 8,
   parameter int SEQ_LEN        = 128,
   parameter int HEADS_PER_BEAT = 4,
   parameter int HEAD_DIM       = 64,
   parameter int HEAD_NUM       = 12
) (
   input  logic clk_p,
   input  logic rst_p,
   input  logic [DATA_WIDTH*SEQ_LEN*HEADS_PER_BEAT*HEAD_DIM-1:0] in_data,
   input  logic in_first,
   input  logic in_valid,
   output logic in_ready,
   output logic [DATA_WIDTH*SEQ_LEN*HEAD_NUM*HEAD_DIM-1:0] out_data,
   output logic out_valid,
   input  logic out_ready,
   output logic err_resync
);

   localparam int BEATS   = HEAD_NUM / HEADS_PER_BEAT;
   localparam int CW      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ROW_IN  = HEADS_PER_BEAT * HEAD_DIM * DATA_WIDTH;
   localparam int ROW_OUT = HEAD_NUM * HEAD_DIM * DATA_WIDTH;
   localparam int OUT_W   = SEQ_LEN * ROW_OUT;

   if (HEAD_NUM % HEADS_PER_BEAT != 0) begin : g_bad_cfg
      $error("HEAD_NUM must be a multiple of HEADS_PER_BEAT");
   end

   typedef enum logic {FILL, HOLD} state_t;

   state_t           state;
   logic [CW-1:0]    beat_cnt;
   logic [OUT_W-1:0] buffer;
   logic             take;
   logic             last;
   logic [CW-1:0]    slot;

   assign in_ready = (state == FILL);
   assign take     = in_valid & in_ready;
   assign out_data = buffer;

   // in_first restarts the group at slot 0 regardless of the running count
   assign slot = in_first ? '0 : beat_cnt;
   assign last = in_first ? (BEATS == 1) : (beat_cnt == CW'(BEATS - 1));

   always_ff @(posedge clk_p) begin
      if (rst_p) begin
         state      <= FILL;
         beat_cnt   <= '0;
         out_valid  <= 1'b0;
         err_resync <= 1'b0;
         buffer     <= '0;
      end else begin
         err_resync <= take & in_first & (beat_cnt != '0);
         if (take) begin
            // heads of one beat are contiguous within each output row
            for (int s = 0; s < SEQ_LEN; s++) begin
               buffer[s*ROW_OUT + int'(slot)*ROW_IN +: ROW_IN]
                  <= in_data[s*ROW_IN +: ROW_IN];
            end
            if (last) begin
               beat_cnt  <= '0;
               state     <= HOLD;
               out_valid <= 1'b1;
            end else if (in_first) begin
               beat_cnt <= CW'(1);
            end else begin
               beat_cnt <= beat_cnt + CW'(1);
            end
         end else if (state == HOLD && out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_head_merge_buffer.sv
// Directed table plus hand sequences and a random reorder check for head_merge_buffer.
// A second instance covers the single-beat (BEATS=1) configuration.
module tb_head_merge_buffer;

   logic         clk = 1'b0;
   logic         rst;
   logic [63:0]  in_data;
   logic         in_first, in_valid, in_ready;
   logic [127:0] out_data;
   logic         out_valid, out_ready, err_resync;

   logic         u1_rst;
   logic [127:0] u1_in_data;
   logic         u1_first, u1_valid, u1_in_ready;
   logic [127:0] u1_out_data;
   logic         u1_out_valid, u1_out_ready, u1_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   head_merge_buffer #(
      .DATA_WIDTH(8), .SEQ_LEN(2), .HEADS_PER_BEAT(2),
      .HEAD_DIM(2), .HEAD_NUM(4)
   ) u0 (
      .clk_p(clk), .rst_p(rst), .in_data(in_data),
      .in_first(in_first), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .err_resync(err_resync)
   );

   head_merge_buffer #(
      .DATA_WIDTH(8), .SEQ_LEN(2), .HEADS_PER_BEAT(4),
      .HEAD_DIM(2), .HEAD_NUM(4)
   ) u1 (
      .clk_p(clk), .rst_p(u1_rst), .in_data(u1_in_data),
      .in_first(u1_first), .in_valid(u1_valid), .in_ready(u1_in_ready),
      .out_data(u1_out_data), .out_valid(u1_out_valid),
      .out_ready(u1_out_ready), .err_resync(u1_err)
   );

   typedef struct {
      logic       rst;
      logic       first;
      logic       valid;
      logic       oready;
      logic [7:0] off;
      logic       ir;
      logic       ov;
      logic       err;
      int         idx;
      logic [7:0] val;
   } vec_t;

   vec_t tbl[19];

   function automatic vec_t mk(input logic r, input logic f, input logic v,
                               input logic o, input logic [7:0] off,
                               input logic ir, input logic ov, input logic er,
                               input int idx, input logic [7:0] val);
      vec_t t;
      t.rst = r; t.first = f; t.valid = v; t.oready = o; t.off = off;
      t.ir = ir; t.ov = ov; t.err = er; t.idx = idx; t.val = val;
      return t;
   endfunction

   // element (s,hb,d) = s*16 + hb*4 + d + off
   function automatic logic [63:0] mkbeat(input logic [7:0] off);
      logic [63:0] r;
      r = '0;
      for (int s = 0; s < 2; s++)
         for (int hb = 0; hb < 2; hb++)
            for (int d = 0; d < 2; d++)
               r[((s*2+hb)*2+d)*8 +: 8] = 8'(s*16 + hb*4 + d) + off;
      return r;
   endfunction

   function automatic logic [127:0] mkbeat4(input logic [7:0] off);
      logic [127:0] r;
      r = '0;
      for (int s = 0; s < 2; s++)
         for (int hb = 0; hb < 4; hb++)
            for (int d = 0; d < 2; d++)
               r[((s*4+hb)*2+d)*8 +: 8] = 8'(s*16 + hb*4 + d) + off;
      return r;
   endfunction

   // reference reorder: out (s,h,d) comes from beat h/2, head h%2
   function automatic logic [127:0] merge(input logic [63:0] b0,
                                         input logic [63:0] b1);
      logic [127:0] r;
      logic [63:0]  src;
      r = '0;
      for (int s = 0; s < 2; s++)
         for (int h = 0; h < 4; h++)
            for (int d = 0; d < 2; d++) begin
               src = (h / 2 == 0) ? b0 : b1;
               r[(s*8 + h*2 + d)*8 +: 8] = src[((s*2 + h%2)*2 + d)*8 +: 8];
            end
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] b[2];
      logic [127:0] exp_m;
      rst = 1'b1; in_data = '0; in_first = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0;
      u1_rst = 1'b1; u1_in_data = '0; u1_first = 1'b0; u1_valid = 1'b0;
      u1_out_ready = 1'b0;

      tbl[0]  = mk(1, 0, 0, 0, 8'h00, 1, 0, 0,  0, 8'h00);
      tbl[1]  = mk(0, 1, 1, 1, 8'h00, 1, 0, 0,  2, 8'h04);
      tbl[2]  = mk(0, 0, 1, 0, 8'h80, 0, 1, 0, 15, 8'h95);
      tbl[3]  = mk(0, 1, 1, 0, 8'h40, 0, 1, 0,  2, 8'h04);
      tbl[4]  = mk(0, 1, 1, 0, 8'h40, 0, 1, 0, 15, 8'h95);
      tbl[5]  = mk(0, 1, 1, 0, 8'h40, 0, 1, 0,  2, 8'h04);
      tbl[6]  = mk(0, 1, 1, 0, 8'h40, 0, 1, 0, 15, 8'h95);
      tbl[7]  = mk(0, 1, 1, 0, 8'h40, 0, 1, 0,  2, 8'h04);
      tbl[8]  = mk(0, 0, 0, 1, 8'h00, 1, 0, 0, 15, 8'h95);
      tbl[9]  = mk(0, 1, 1, 0, 8'h40, 1, 0, 0,  2, 8'h44);
      tbl[10] = mk(0, 1, 1, 0, 8'h20, 1, 0, 1,  2, 8'h24);
      tbl[11] = mk(0, 0, 1, 0, 8'h60, 0, 1, 0, 15, 8'h75);
      tbl[12] = mk(0, 0, 0, 1, 8'h00, 1, 0, 0,  0, 8'h20);
      tbl[13] = mk(0, 1, 1, 0, 8'h10, 1, 0, 0,  2, 8'h14);
      tbl[14] = mk(1, 0, 1, 1, 8'h80, 1, 0, 0,  2, 8'h00);
      tbl[15] = mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 15, 8'h00);
      tbl[16] = mk(0, 0, 1, 0, 8'h00, 1, 0, 0,  2, 8'h04);
      tbl[17] = mk(0, 0, 1, 0, 8'h80, 0, 1, 0, 15, 8'h95);
      tbl[18] = mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 15, 8'h00);

      for (int i = 0; i < 19; i++) begin
         rst       = tbl[i].rst;
         in_first  = tbl[i].first;
         in_valid  = tbl[i].valid;
         out_ready = tbl[i].oready;
         in_data   = mkbeat(tbl[i].off);
         step();
         chk($sformatf("row%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].ir));
         chk($sformatf("row%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].ov));
         chk($sformatf("row%0d_err_resync", i), 128'(err_resync), 128'(tbl[i].err));
         chk($sformatf("row%0d_elem%0d", i, tbl[i].idx),
             128'(out_data[tbl[i].idx*8 +: 8]), 128'(tbl[i].val));
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      step();

      // random gaps on both sides; every matrix checked against the reorder model
      for (int m = 0; m < 50; m++) begin
         b[0] = {$urandom, $urandom};
         b[1] = {$urandom, $urandom};
         for (int k = 0; k < 2; k++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            in_data  = b[k];
            in_first = (k == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_valid = 1'b1;
            chk($sformatf("rnd%0d_in_ready%0d", m, k), 128'(in_ready), 128'(1'b1));
            step();
         end
         chk($sformatf("rnd%0d_out_valid", m), 128'(out_valid), 128'(1'b1));
         in_data  = {$urandom, $urandom};
         in_first = 1'b1;
         in_valid = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 3)) step();
         exp_m = merge(b[0], b[1]);
         chk($sformatf("rnd%0d_out_data", m), out_data, exp_m);
         chk($sformatf("rnd%0d_no_err", m), 128'(err_resync), 128'(1'b0));
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         in_valid  = 1'b0;
         chk($sformatf("rnd%0d_released", m), 128'(out_valid), 128'(1'b0));
      end

      // single-beat configuration
      step();
      u1_rst = 1'b0;
      chk("b1_reset_ready", 128'(u1_in_ready), 128'(1'b1));
      u1_in_data = mkbeat4(8'h00); u1_first = 1'b1; u1_valid = 1'b1;
      step();
      chk("b1_ov_first", 128'(u1_out_valid), 128'(1'b1));
      chk("b1_ir_hold", 128'(u1_in_ready), 128'(1'b0));
      chk("b1_err_first", 128'(u1_err), 128'(1'b0));
      chk("b1_elem15", 128'(u1_out_data[15*8 +: 8]), 128'(8'h1d));
      u1_in_data = mkbeat4(8'h40); u1_out_ready = 1'b1;
      step();
      chk("b1_released", 128'(u1_out_valid), 128'(1'b0));
      chk("b1_ignored_beat", 128'(u1_out_data[15*8 +: 8]), 128'(8'h1d));
      u1_in_data = mkbeat4(8'h80); u1_first = 1'b0; u1_out_ready = 1'b0;
      step();
      chk("b1_ov_second", 128'(u1_out_valid), 128'(1'b1));
      chk("b1_err_second", 128'(u1_err), 128'(1'b0));
      chk("b1_elem15_second", 128'(u1_out_data[15*8 +: 8]), 128'(8'h9d));
      u1_valid = 1'b0; u1_out_ready = 1'b1;
      step();
      chk("b1_released2", 128'(u1_out_valid), 128'(1'b0));
      chk("b1_err_idle", 128'(u1_err), 128'(1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
